// File: rtl/memory_subsystem.sv
`default_nettype none
// ============================================================================
// Module      : memory_subsystem
// Description : Bus-attached main memory for the Hmmm CPU. A Memory Address
//               Register (MAR) is loaded from the shared system bus; a
//               256 x 16 RAM is written from the bus through the Memory Data
//               Register (MDR) path, or read back onto the bus asynchronously.
// Ports       :
//   clk      in     1            system clock, rising-edge active
//   rst      in     1            synchronous reset, active low
//   mar_in   in     1            load MAR from bus[ADDR_WIDTH-1:0]
//   mdr_in   in     1            capture bus into MDR and RAM[MAR]
//   mdr_out  in     1            drive RAM[MAR] onto the bus
//   bus      inout  DATA_WIDTH   shared tri-state system bus
//   mar_q    out    ADDR_WIDTH   current MAR value
// Revision    : 1.0 - initial release
// ============================================================================
module memory_subsystem #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mar_in,
  input  logic                  mdr_in,
  input  logic                  mdr_out,
  inout  wire  [DATA_WIDTH-1:0] bus,
  output logic [ADDR_WIDTH-1:0] mar_q
);

  logic [ADDR_WIDTH-1:0] mar;
  logic [DATA_WIDTH-1:0] mdr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata;
  logic                  drive_bus;

  // Address register. Only the low address bits of the bus are sampled, so
  // wider values wrap around the memory size.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mar <= '0;
    end else if (mar_in) begin
      mar <= bus[ADDR_WIDTH-1:0];
    end
  end

  // Data register and RAM write. The write targets the MAR value from before
  // the edge, so a same-edge MAR load redirects only later accesses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mdr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mdr_in) begin
      mdr      <= bus;
      mem[mar] <= bus;
    end
  end

  // Asynchronous read: data follows MAR and the addressed word with no
  // additional register stage.
  assign rdata = mem[mar];

  // mdr_in wins over mdr_out so the block never fights the bus master that
  // is supplying write data; reset also releases the bus.
  assign drive_bus = mdr_out && !mdr_in && rst;
  assign bus       = drive_bus ? rdata : {DATA_WIDTH{1'bz}};

  assign mar_q = mar;

endmodule
`default_nettype wire

// File: tb/tb_memory_subsystem.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_subsystem
// Description : Self-checking bench for memory_subsystem. A behavioural
//               memory model (array + address) predicts bus read data and
//               MAR for directed scenarios and random strobe sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_subsystem;

  logic        clk;
  logic        rst;
  logic        mar_in;
  logic        mdr_in;
  logic        mdr_out;
  wire  [15:0] bus;
  logic [7:0]  mar_q;

  logic        tb_en;
  logic [15:0] tb_val;

  int checks;
  int failures;

  // Reference model state
  logic [15:0] model_mem [256];
  logic [7:0]  model_mar;
  logic [15:0] last_bus;

  assign bus = tb_en ? tb_val : 16'hzzzz;

  memory_subsystem #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(8),
    .DEPTH     (256)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .mar_in (mar_in),
    .mdr_in (mdr_in),
    .mdr_out(mdr_out),
    .bus    (bus),
    .mar_q  (mar_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%04h expected=0x%04h", tag, got, exp);
    end
  endtask

  // One clock cycle of stimulus. Called 1 time unit after a rising edge;
  // checks bus and MAR mid-cycle, then advances the model across the edge.
  task automatic cycle(input logic r, input logic mi, input logic wi,
                       input logic ro, input logic [15:0] v);
    logic        dut_drives;
    logic [15:0] exp_bus;
    rst     = r;
    mar_in  = mi;
    mdr_in  = wi;
    mdr_out = ro;
    dut_drives = ro && !wi && r;
    // Whenever the memory should be silent the bench drives the bus; reading
    // back its own value shows the memory is not fighting it.
    tb_en   = !dut_drives;
    tb_val  = v;
    exp_bus = dut_drives ? model_mem[model_mar] : v;
    #4;
    last_bus = bus;
    check(dut_drives ? "bus_read" : "bus_release", bus, exp_bus);
    check("mar_q", {8'h00, mar_q}, {8'h00, model_mar});
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
      model_mar = 8'h00;
    end else begin
      if (wi) model_mem[model_mar] = exp_bus;
      if (mi) model_mar = exp_bus[7:0];
    end
    #1;
  endtask

  task automatic load_mar(input logic [15:0] a);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, a);
  endtask

  task automatic write_data(input logic [15:0] d);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic read_cur;
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
  endtask

  task automatic idle;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'(($urandom)));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    mar_in   = 1'b0;
    mdr_in   = 1'b0;
    mdr_out  = 1'b0;
    tb_en    = 1'b1;
    tb_val   = 16'h0000;
    last_bus = 16'h0000;

    // Initial reset: MAR/RAM are unknown before the first edge, so the
    // model is only set once the reset edge has happened.
    @(posedge clk);
    for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
    model_mar = 8'h00;
    #1;

    // Reset and idle
    idle();
    check("reset_mar", {8'h00, mar_q}, 16'h0000);
    for (int a = 0; a < 256; a++) begin
      load_mar(16'(a));
      read_cur();
      if (last_bus !== 16'h0000) check("reset_ram", last_bus, 16'h0000);
    end
    checks++;  // one summarising count for the sweep above

    // Write/read one location
    load_mar(16'd42);
    write_data(16'd21);
    idle();
    read_cur();
    check("rd42", last_bus, 16'd21);
    check("mar42", {8'h00, mar_q}, 16'd42);

    // Two writes, then reads
    load_mar(16'd32);
    write_data(16'd24);
    load_mar(16'd33);
    write_data(16'd25);
    load_mar(16'd32);
    read_cur();
    check("rd32", last_bus, 16'd24);
    load_mar(16'd33);
    read_cur();
    check("rd33", last_bus, 16'd25);
    load_mar(16'd42);
    read_cur();
    check("rd42_again", last_bus, 16'd21);

    // Address truncation
    load_mar(16'h012A);
    check("trunc_mar", {8'h00, mar_q}, 16'h002A);
    read_cur();
    check("trunc_rd", last_bus, 16'd21);

    // Same-edge mar_in + mdr_in
    load_mar(16'd5);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0007);
    check("same_edge_mar", {8'h00, mar_q}, 16'h0007);
    read_cur();
    check("same_edge_rd7", last_bus, 16'h0000);
    load_mar(16'd5);
    read_cur();
    check("same_edge_rd5", last_bus, 16'h0007);

    // mdr_in + mdr_out: write wins, bus released (bench value read back)
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'h1234);
    check("wr_prio_bus", last_bus, 16'h1234);
    read_cur();
    check("wr_prio_rd", last_bus, 16'h1234);

    // mar_in + mdr_out: MAR samples the memory's own read data
    load_mar(16'd9);
    write_data(16'h0021);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);
    check("mar_from_mem", {8'h00, mar_q}, 16'h0021);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic        r, mi, wi, ro;
      logic [15:0] v;
      r  = ($urandom % 150) != 0;
      mi = ($urandom % 3) == 0;
      wi = ($urandom % 4) == 0;
      ro = ($urandom % 2) == 0;
      v  = 16'($urandom);
      if (($urandom % 4) != 0) v[7:4] = 4'h0;  // concentrate on few addresses
      cycle(r, mi, wi, ro, v);
    end

    // Reset mid-operation dominates a write
    load_mar(16'd77);
    write_data(16'h5555);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'hBEEF);
    check("rst_mar", {8'h00, mar_q}, 16'h0000);
    read_cur();
    check("rst_rd0", last_bus, 16'h0000);
    load_mar(16'd77);
    read_cur();
    check("rst_rd77", last_bus, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stalled simulation
  initial begin
    #2000000;
    $display("FAIL timeout: got=stalled expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/memory_subsystem.md
Name:
memory_subsystem

Overview:
- Bus-attached main memory for the Hmmm CPU.
- Combines three parts:
  - a Memory Address Register (MAR);
  - a 256 x 16 word RAM;
  - a Memory Data Register (MDR) interface onto the shared 16-bit tri-state system bus.
- Address is loaded from the bus in one cycle. Data is written from the bus, or driven onto the bus, in a later cycle under control-unit strobes.

Parameters:
- DATA_WIDTH, 16, width of bus, MDR and RAM words.
- ADDR_WIDTH, 8, width of MAR and RAM address.
- DEPTH, 256, number of RAM words (2**ADDR_WIDTH).

Ports:
- clk      input   1   system clock; all state updates on the rising edge.
- rst      input   1   synchronous, active-low reset (asserted when 0, sampled on the rising clk edge).
- mar_in   input   1   load MAR from bus[ADDR_WIDTH-1:0] at the next edge.
- mdr_in   input   1   capture the bus into the MDR and write it to RAM[MAR] at the next edge.
- mdr_out  input   1   drive RAM[MAR] onto the bus (combinational).
- bus      inout   16  shared system bus.
- mar_q    output  8   current MAR value (debug/observation).

Behaviour:
- Reset (rst==0 at a rising edge):
  - MAR <= 0 and MDR <= 0.
  - All RAM words are cleared to 0.
  - No write occurs that cycle; reset dominates all strobes.
  - While rst is held low, the bus is not driven.
- MAR:
  - On a rising edge with rst==1 and mar_in==1: MAR <= bus[7:0].
  - bus[15:8] is ignored, so address values wrap modulo 256.
  - Otherwise MAR holds.
  - mar_q = MAR at all times.
- Write:
  - On a rising edge with rst==1 and mdr_in==1: RAM[MAR] <= bus and MDR <= bus.
  - The write uses the MAR value before that edge.
  - A write is therefore visible on the first read issued after the edge.
- Read:
  - RAM read is asynchronous: rdata = RAM[MAR], updating combinationally when MAR or the addressed word changes.
  - No read latency beyond MAR load: mar_in at edge N, then mdr_out during cycle N+1 presents data before edge N+2.
- Bus drive:
  - bus = rdata when mdr_out==1, mdr_in==0 and rst==1.
  - Otherwise the bus is high-impedance (all 16 bits Z).
- Simultaneous events:
  - mar_in and mdr_in both high: the write goes to the old MAR address; MAR loads the new address at the same edge.
  - mdr_in and mdr_out both high: mdr_in has priority. The block releases the bus (no contention) and performs the write.
  - mar_in and mdr_out both high: the bus is driven with RAM[old MAR]. That value is also what MAR samples (bus[7:0]), which is legal but the control unit must avoid it.
- No strobe asserted: all state holds and the bus is Z.
- Implementation:
  - The RAM array is a reg array with a synchronous write and asynchronous read.
  - The tri-state uses a conditional assign on bus.

Test Plan:
- Reset and idle: hold rst=0 for one edge, then release; all strobes low -> mar_q==0, bus==Z, RAM[0..255]==0.
- Write/read one location:
  - Bench drives 42 with mar_in=1 for one edge, then 21 with mdr_in=1 for one edge, then releases the bus.
  - Then assert mdr_out -> bus==21 during that cycle, and mar_q==42.
- Two writes, then reads:
  - Write 24 to address 32 and 25 to address 33.
  - Load MAR=32 and assert mdr_out -> bus==24.
  - Load MAR=33 and assert mdr_out -> bus==25.
  - Address 42 still reads 21.
- Address truncation: bench drives 0x012A with mar_in=1 -> mar_q==0x2A; a subsequent read returns RAM[42].
- Same-edge mar_in+mdr_in: MAR=5, then drive 0x0007 with mar_in=1 and mdr_in=1 -> RAM[5]==0x0007, mar_q==7, RAM[7] unchanged.
- Reset mid-operation: rst=0 on the same edge as mdr_in=1 with bus=0xBEEF -> no write; RAM[MAR]==0, mar_q==0.
